// File: rtl/cpm_pkg.sv
// Shared defaults and the queue entry layout for the CPM request queue.
package cpm_pkg;

    localparam int CPM_REQ_DW  = 4;
    localparam int CPM_IDX_AW  = 2;
    localparam int CPM_ADDR_AW = 10;
    localparam int CPM_DEPTH   = 4;

    typedef struct packed {
        logic [CPM_IDX_AW-1:0]  idx;
        logic [CPM_ADDR_AW-1:0] addr;
    } cpm_entry_t;

endpackage

// File: rtl/cpm_req_que_if.sv
// Request-side, arbiter-side and bank-side bundle of the CPM request queue.
interface cpm_req_que_if
    import cpm_pkg::*;
#(
    parameter int REQ_DW  = CPM_REQ_DW,
    parameter int IDX_AW  = CPM_IDX_AW,
    parameter int ADDR_AW = CPM_ADDR_AW
);
    logic [REQ_DW-1:0]         in_vld;
    logic [REQ_DW-1:0]         in_rdy;
    logic [REQ_DW*IDX_AW-1:0]  in_idx;
    logic [REQ_DW*ADDR_AW-1:0] in_addr;
    logic [REQ_DW-1:0]         REQ_ARB;
    logic [REQ_DW*IDX_AW-1:0]  REQ_IDX;
    logic [REQ_DW-1:0]         GNT_ARB;
    logic [REQ_DW-1:0]         bank_vld;
    logic [REQ_DW*ADDR_AW-1:0] bank_addr;
    logic [REQ_DW*IDX_AW-1:0]  bank_src;
    logic [REQ_DW-1:0]         age_hi;
    logic                      err;

    modport master (
        output in_vld, in_idx, in_addr, GNT_ARB,
        input  in_rdy, REQ_ARB, REQ_IDX, bank_vld, bank_addr, bank_src, age_hi, err
    );

    modport slave (
        input  in_vld, in_idx, in_addr, GNT_ARB,
        output in_rdy, REQ_ARB, REQ_IDX, bank_vld, bank_addr, bank_src, age_hi, err
    );
endinterface

// File: rtl/cpm_req_fifo.sv
// One per-port request FIFO; pointers carry an extra wrap bit to tell full from empty.
module cpm_req_fifo
    import cpm_pkg::*;
#(
    parameter int DEPTH = CPM_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  cpm_entry_t din,
    output cpm_entry_t dout,
    output logic       empty,
    output logic       full
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;
    cpm_entry_t  mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    // full comes from registered pointers, so a same-cycle pop never frees room for a push
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/cpm_req_que.sv
// Per-port request queues feeding an external arbiter and driving per-bank strobes.
// Optional head-of-queue age tracking is enabled by defining CPM_REQ_AGE_EN.
module cpm_req_que
    import cpm_pkg::*;
#(
    parameter int REQ_DW  = CPM_REQ_DW,
    parameter int IDX_AW  = CPM_IDX_AW,
    parameter int ADDR_AW = CPM_ADDR_AW,
    parameter int DEPTH   = CPM_DEPTH,
    parameter int AGE_TH  = 8
) (
    input logic           clk,
    input logic           rst_n,
    cpm_req_que_if.slave  bus
);
    logic [REQ_DW-1:0]         empty;
    logic [REQ_DW-1:0]         full;
    logic [REQ_DW-1:0]         pop;
    cpm_entry_t                din  [REQ_DW];
    cpm_entry_t                head [REQ_DW];
    logic [REQ_DW*IDX_AW-1:0]  req_idx;

    logic [REQ_DW-1:0]         bank_vld;
    logic [REQ_DW*ADDR_AW-1:0] bank_addr;
    logic [REQ_DW*IDX_AW-1:0]  bank_src;
    logic                      err;

    logic [REQ_DW-1:0]         bvld_n;
    logic [REQ_DW*ADDR_AW-1:0] baddr_n;
    logic [REQ_DW*IDX_AW-1:0]  bsrc_n;
    logic                      dbl;

    for (genvar i = 0; i < REQ_DW; i++) begin : g_port
        assign din[i] = '{idx:  bus.in_idx[i*IDX_AW +: IDX_AW],
                          addr: bus.in_addr[i*ADDR_AW +: ADDR_AW]};

        cpm_req_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (bus.in_vld[i]),
            .pop   (pop[i]),
            .din   (din[i]),
            .dout  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    always_comb begin
        req_idx = '0;
        for (int i = 0; i < REQ_DW; i++) req_idx[i*IDX_AW +: IDX_AW] = head[i].idx;
    end

    assign pop         = bus.GNT_ARB & ~empty;
    assign bus.in_rdy  = ~full;
    assign bus.REQ_ARB = ~empty;
    assign bus.REQ_IDX = req_idx;

    // Ports are scanned high to low so the lowest popping port ends up owning a shared bank.
    always_comb begin
        bvld_n  = '0;
        baddr_n = bank_addr;
        bsrc_n  = bank_src;
        dbl     = 1'b0;
        for (int b = 0; b < REQ_DW; b++) begin
            for (int i = REQ_DW - 1; i >= 0; i--) begin
                if (pop[i] && int'(head[i].idx) == b) begin
                    if (bvld_n[b]) dbl = 1'b1;
                    bvld_n[b]                    = 1'b1;
                    baddr_n[b*ADDR_AW +: ADDR_AW] = head[i].addr;
                    bsrc_n[b*IDX_AW +: IDX_AW]    = IDX_AW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_vld  <= '0;
            bank_addr <= '0;
            bank_src  <= '0;
            err       <= 1'b0;
        end else begin
            bank_vld  <= bvld_n;
            bank_addr <= baddr_n;
            bank_src  <= bsrc_n;
            err       <= err | dbl;
        end
    end

    assign bus.bank_vld  = bank_vld;
    assign bus.bank_addr = bank_addr;
    assign bus.bank_src  = bank_src;
    assign bus.err       = err;

`ifdef CPM_REQ_AGE_EN
    logic [3:0]        age   [REQ_DW];
    logic [3:0]        age_n [REQ_DW];
    logic [REQ_DW-1:0] age_hi;

    // A waiting head counts up; an empty queue or a grant (pop) restarts it.
    always_comb begin
        for (int i = 0; i < REQ_DW; i++) begin
            age_n[i] = age[i];
            if (empty[i] || bus.GNT_ARB[i]) age_n[i] = 4'd0;
            else if (age[i] != 4'hF)        age_n[i] = age[i] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_DW; i++) age[i] <= 4'd0;
            age_hi <= '0;
        end else begin
            for (int i = 0; i < REQ_DW; i++) begin
                age[i]    <= age_n[i];
                age_hi[i] <= (32'(age_n[i]) >= AGE_TH);
            end
        end
    end

    assign bus.age_hi = age_hi;
`else
    assign bus.age_hi = '0;
`endif
endmodule
